// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and FSM state type for the MEM pipeline stage
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [4:0] RA_ADDR = 5'd31;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte lane of a load and sign/zero-extends it
module load_align
  import pipe_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic              byte_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] data_o
);
  logic [7:0] lane;
  assign lane = rdata_i[{offset_i, 3'b000} +: 8];
  assign data_o = byte_i ? {{24{sign_i & lane[7]}}, lane} : rdata_i;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a req/ack data-memory port and the WB registers
// Define ALIGN_CHECK_EN to reject misaligned word accesses with a misalign_err pulse.
module mem_access_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC_MEM,
  input  logic [DATA_W-1:0] ALU_OUT_MEM,
  input  logic [DATA_W-1:0] MEM_WRITE_MEM,
  input  logic [DATA_W-1:0] REG_WRITE,
  input  logic [4:0]        REG_WRITE_ADDR,
  input  logic              RegWr_MEM,
  input  logic              MemRd_MEM,
  input  logic              MemWr_MEM,
  input  logic              SigCtr_MEM,
  input  logic              byte_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] PC_WB,
  output logic              RegWr_WB,
  output logic [4:0]        REG_WRITE_ADDR_WB,
  output logic [DATA_W-1:0] REG_WRITE_DATA_WB,
  output logic              misalign_err
);
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, rw_q, rw_d;
  logic [3:0] be_q, be_d;
  logic [4:0] wa_q, wa_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d, wd_q, wd_d, ld_data;
  logic is_mem, mis;
  assign is_mem = MemRd_MEM | MemWr_MEM;
`ifdef ALIGN_CHECK_EN
  logic mis_q;
  assign mis = is_mem & ~byte_MEM & (ALU_OUT_MEM[1:0] != 2'b00);
  always_ff @(posedge clk) mis_q <= rst & (state_q == IDLE) & mis;
  assign misalign_err = mis_q;
`else
  assign mis = 1'b0;
  assign misalign_err = 1'b0;
`endif
  load_align u_load_align (
    .rdata_i (dmem_rdata),
    .offset_i(ALU_OUT_MEM[1:0]),
    .byte_i  (byte_MEM),
    .sign_i  (SigCtr_MEM),
    .data_o  (ld_data)
  );
  // WB registers default to a bubble; only completed or non-memory ops load them
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    pc_d = '0;
    rw_d = 1'b0;
    wa_d = '0;
    wd_d = '0;
    stall = 1'b0;
    if (state_q == IDLE) begin
      if (is_mem && !mis) begin
        stall = 1'b1;
        state_d = BUSY;
        req_d = 1'b1;
        we_d = MemWr_MEM;
        be_d = byte_MEM ? 4'b0001 << ALU_OUT_MEM[1:0] : BE_WORD;
        addr_d = {ALU_OUT_MEM[31:2], 2'b00};
        wdata_d = byte_MEM ? {4{MEM_WRITE_MEM[7:0]}} : MEM_WRITE_MEM;
      end else begin
        pc_d = PC_MEM;
        rw_d = RegWr_MEM & ~mis;
        wa_d = REG_WRITE_ADDR;
        wd_d = REG_WRITE;
      end
    end else if (dmem_ack) begin
      state_d = IDLE;
      req_d = 1'b0;
      pc_d = PC_MEM;
      rw_d = RegWr_MEM;
      wa_d = REG_WRITE_ADDR;
      wd_d = we_q ? REG_WRITE : ld_data;
    end else begin
      stall = 1'b1;
    end
    if (!rst) stall = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      pc_q <= '0;
      rw_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      pc_q <= pc_d;
      rw_q <= rw_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end
  assign dmem_req = req_q;
  assign dmem_we = we_q;
  assign dmem_be = be_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = wdata_q;
  assign PC_WB = pc_q;
  assign RegWr_WB = rw_q;
  assign REG_WRITE_ADDR_WB = wa_q;
  assign REG_WRITE_DATA_WB = wd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of mem_access_stage against a transaction-level model
// Honours ALIGN_CHECK_EN the same way as the design.
module tb_mem_access_stage;
  import pipe_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mis;
  } wb_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] PC_MEM, ALU_OUT_MEM, MEM_WRITE_MEM, REG_WRITE, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] PC_WB, REG_WRITE_DATA_WB;
  logic [4:0] REG_WRITE_ADDR, REG_WRITE_ADDR_WB;
  logic RegWr_MEM, MemRd_MEM, MemWr_MEM, SigCtr_MEM, byte_MEM;
  logic dmem_req, dmem_we, dmem_ack, stall, RegWr_WB, misalign_err;
  logic [3:0] dmem_be;
  int checks = 0, failures = 0, stall_cnt = 0;
  logic chk_en = 1'b0;
  logic exp_stall, exp_req, exp_we;
  logic [3:0] exp_be;
  logic [31:0] exp_addr, exp_wdata;
  wb_t exp_wb, carry;
  always #5 clk = ~clk;
  mem_access_stage dut (
    .clk(clk), .rst(rst), .PC_MEM(PC_MEM), .ALU_OUT_MEM(ALU_OUT_MEM),
    .MEM_WRITE_MEM(MEM_WRITE_MEM), .REG_WRITE(REG_WRITE), .REG_WRITE_ADDR(REG_WRITE_ADDR),
    .RegWr_MEM(RegWr_MEM), .MemRd_MEM(MemRd_MEM), .MemWr_MEM(MemWr_MEM),
    .SigCtr_MEM(SigCtr_MEM), .byte_MEM(byte_MEM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .PC_WB(PC_WB), .RegWr_WB(RegWr_WB),
    .REG_WRITE_ADDR_WB(REG_WRITE_ADDR_WB), .REG_WRITE_DATA_WB(REG_WRITE_DATA_WB),
    .misalign_err(misalign_err)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic wb_t mk(input logic [31:0] pc, input logic rw, input logic [4:0] wa,
                             input logic [31:0] wd, input logic mis);
    wb_t w;
    w.pc = pc; w.rw = rw; w.wa = wa; w.wd = wd; w.mis = mis;
    return w;
  endfunction
  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [31:0] rd,
                                           input logic byt, input logic sgn);
    int lane;
    lane = int'((rd >> (8 * a[1:0])) & 32'hFF);
    if (!byt) return rd;
    return (sgn && lane >= 128) ? 32'(lane - 256) : 32'(lane);
  endfunction
  always @(negedge clk) begin
    if (stall === 1'b1) stall_cnt++;
    if (chk_en) begin
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
      check("PC_WB", PC_WB, exp_wb.pc);
      check("RegWr_WB", {31'b0, RegWr_WB}, {31'b0, exp_wb.rw});
      check("REG_WRITE_ADDR_WB", {27'b0, REG_WRITE_ADDR_WB}, {27'b0, exp_wb.wa});
      check("REG_WRITE_DATA_WB", REG_WRITE_DATA_WB, exp_wb.wd);
      check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_wb.mis});
      if (exp_req) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
        check("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end
  task automatic step(input logic ack, input logic st, input logic rq, input wb_t prod);
    dmem_ack = ack;
    exp_stall = st;
    exp_req = rq;
    exp_wb = carry;
    carry = prod;
    @(posedge clk);
    #1;
  endtask
  task automatic nop(input logic [31:0] pc, input logic rw, input logic [4:0] wa,
                     input logic [31:0] d, input logic ack);
    PC_MEM = pc; RegWr_MEM = rw; REG_WRITE_ADDR = wa; REG_WRITE = d;
    MemRd_MEM = 1'b0; MemWr_MEM = 1'b0; ALU_OUT_MEM = 32'h0; byte_MEM = 1'b0;
    step(ack, 1'b0, 1'b0, mk(pc, rw, wa, d, 1'b0));
  endtask
  task automatic set_op(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rv, input logic rd, input logic wr, input logic byt,
                        input logic sgn, input logic rw, input logic [4:0] wa, input logic [31:0] rdata);
    PC_MEM = pc; ALU_OUT_MEM = a; MEM_WRITE_MEM = sd; REG_WRITE = rv; MemRd_MEM = rd;
    MemWr_MEM = wr; byte_MEM = byt; SigCtr_MEM = sgn; RegWr_MEM = rw; REG_WRITE_ADDR = wa;
    dmem_rdata = rdata;
    exp_addr = a & ~32'h3;
    exp_be = byt ? 4'(1 << a[1:0]) : 4'hF;
    exp_we = wr;
    exp_wdata = byt ? 32'(sd[7:0]) * 32'h01010101 : sd;
  endtask
  task automatic mem_op(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rv, input logic rd, input logic wr, input logic byt,
                        input logic sgn, input logic rw, input logic [4:0] wa, input int dly,
                        input logic [31:0] rdata);
    set_op(pc, a, sd, rv, rd, wr, byt, sgn, rw, wa, rdata);
`ifdef ALIGN_CHECK_EN
    if (!byt && a[1:0] != 2'b00) begin
      step(1'b0, 1'b0, 1'b0, mk(pc, 1'b0, wa, rv, 1'b1));
      return;
    end
`endif
    step(1'b0, 1'b1, 1'b0, '0);
    repeat (dly) step(1'b0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, mk(pc, rw, wa, wr ? rv : load_val(a, rdata, byt, sgn), 1'b0));
    dmem_ack = 1'b0;
  endtask
  initial begin
    int s0;
    dmem_ack = 1'b0; dmem_rdata = '0; SigCtr_MEM = 1'b0; MEM_WRITE_MEM = '0;
    PC_MEM = '0; RegWr_MEM = 1'b0; REG_WRITE_ADDR = '0; REG_WRITE = '0;
    MemRd_MEM = 1'b0; MemWr_MEM = 1'b0; ALU_OUT_MEM = '0; byte_MEM = 1'b0;
    carry = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset dmem_req", {31'b0, dmem_req}, 32'd0);
    check("reset WB data", REG_WRITE_DATA_WB, 32'h0);
    check("reset misalign", {31'b0, misalign_err}, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    s0 = stall_cnt;
    nop(32'h40, 1'b1, 5'd5, 32'h1234, 1'b1);
    check("nop WB data", REG_WRITE_DATA_WB, 32'h1234);
    check("nop WB addr", {27'b0, REG_WRITE_ADDR_WB}, 32'd5);
    nop(32'h44, 1'b1, 5'd6, 32'h5555, 1'b0);
    check("nop no stall", stall_cnt - s0, 0);
    s0 = stall_cnt;
    mem_op(32'h48, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RA_ADDR, 3, 32'hDEADBEEF);
    check("word load stall cycles", stall_cnt - s0, 4);
    check("word load WB data", REG_WRITE_DATA_WB, 32'hDEADBEEF);
    check("req drop after ack", {31'b0, dmem_req}, 32'd0);
    mem_op(32'h4C, 32'h103, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 0, 32'h80112233);
    check("lb signed", REG_WRITE_DATA_WB, 32'hFFFFFF80);
    mem_op(32'h50, 32'h103, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1, 32'h80112233);
    check("lb unsigned", REG_WRITE_DATA_WB, 32'h00000080);
    mem_op(32'h54, 32'h102, 32'h123456AB, 32'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 1, 32'h0);
    check("sb be", {28'b0, dmem_be}, 32'h4);
    check("sb wdata", dmem_wdata, 32'hABABABAB);
    check("sb we", {31'b0, dmem_we}, 32'd1);
    check("sb RegWr_WB", {31'b0, RegWr_WB}, 32'd0);
    mem_op(32'h58, 32'h201, 32'hCAFEF00D, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 2, 32'h0);
    check("rd+wr is write", {31'b0, dmem_we}, 32'd1);
    mem_op(32'h5C, 32'h102, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1, 32'h11223344);
`ifdef ALIGN_CHECK_EN
    check("misalign pulse", {31'b0, misalign_err}, 32'd1);
    check("misalign no req", {31'b0, dmem_req}, 32'd0);
    check("misalign RegWr_WB", {31'b0, RegWr_WB}, 32'd0);
`else
    check("misaligned word addr", dmem_addr, 32'h100);
    check("misaligned word data", REG_WRITE_DATA_WB, 32'h11223344);
`endif
    nop(32'h60, 1'b1, 5'd12, 32'h6060, 1'b0);
    set_op(32'h64, 32'h300, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 32'hFFFF0000);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, '0);
    rst = 1'b1;
    check("abort dmem_req", {31'b0, dmem_req}, 32'd0);
    check("abort dmem_addr", dmem_addr, 32'h0);
    check("abort dmem_be", {28'b0, dmem_be}, 32'h0);
    check("abort PC_WB", PC_WB, 32'h0);
    nop(32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    nop(32'h68, 1'b1, 5'd14, 32'h6868, 1'b0);
    nop(32'h6C, 1'b0, 5'd0, 32'h0, 1'b0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst in 1, synchronous active-low reset.
REQ-002 SHALL have EX/MEM-side inputs: PC_MEM 32, ALU_OUT_MEM 32 (address), MEM_WRITE_MEM 32 (store data), REG_WRITE 32 (non-load result), REG_WRITE_ADDR 5, RegWr_MEM 1, MemRd_MEM 1, MemWr_MEM 1, SigCtr_MEM 1 (1 = sign-extend byte load), byte_MEM 1.
REQ-003 SHALL have data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_be out 4, dmem_ack in 1, dmem_rdata in 32.
REQ-004 SHALL have pipeline-control and WB ports: stall out 1 (holds all upstream stages), PC_WB out 32, RegWr_WB out 1, REG_WRITE_ADDR_WB out 5, REG_WRITE_DATA_WB out 32, misalign_err out 1.

Function
REQ-005 SHALL implement FSM states IDLE and BUSY.
REQ-006 Non-memory op (MemRd_MEM = MemWr_MEM = 0) in IDLE: stall = 0; WB registers SHALL load PC_MEM, RegWr_MEM, REG_WRITE_ADDR, REG_WRITE at the next edge (latency 1).
REQ-007 Memory op in IDLE: stall = 1; the bus registers SHALL capture the address, write data, byte enables and write enable; the FSM SHALL go to BUSY; the WB registers SHALL load a bubble (all zero).
REQ-008 In BUSY, dmem_req = 1, and dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL stay stable until dmem_ack.
REQ-009 In BUSY with dmem_ack = 0: stall = 1 and the WB registers SHALL load a bubble.
REQ-010 In BUSY with dmem_ack = 1: stall = 0; the WB registers SHALL load (load data for a read, REG_WRITE for a write) plus RegWr_MEM, REG_WRITE_ADDR and PC_MEM; the FSM SHALL return to IDLE; dmem_req SHALL drop at that edge. The minimum memory-op latency is 2 cycles.
REQ-011 dmem_addr SHALL be {ALU_OUT_MEM[31:2], 2'b00}.
REQ-012 Word access: dmem_be = 4'hF; dmem_wdata = MEM_WRITE_MEM.
REQ-013 Byte store: dmem_be = 1 << ALU_OUT_MEM[1:0] (little-endian); dmem_wdata = MEM_WRITE_MEM[7:0] replicated into all four lanes.
REQ-014 Byte load: the lane selected by ALU_OUT_MEM[1:0] SHALL be sign-extended when SigCtr_MEM = 1, else zero-extended. Word load SHALL pass dmem_rdata unchanged.
REQ-015 dmem_ack while in IDLE SHALL be ignored.
REQ-016 MemRd_MEM and MemWr_MEM both 1 SHALL be treated as a write.
REQ-017 Upstream inputs SHALL be sampled only in IDLE; the EX/MEM register holds them while stall = 1.

Reset
REQ-018 rst = 0 at a clock edge SHALL force: IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; all WB outputs = 0; misalign_err = 0.
REQ-019 While rst = 0, stall SHALL be 0.
REQ-020 Reset asserted in BUSY SHALL abandon the access; dmem_req SHALL be 0 from the next cycle, and a late dmem_ack SHALL be ignored.

Configuration
REQ-021 Macro ALIGN_CHECK_EN SHALL control alignment checking.
REQ-022 With ALIGN_CHECK_EN defined: a word access with ALU_OUT_MEM[1:0] != 0 in IDLE SHALL issue no bus request and SHALL NOT enter BUSY; stall = 0; misalign_err SHALL pulse for 1 cycle (registered); the WB registers SHALL load with RegWr_WB = 0.
REQ-023 Without ALIGN_CHECK_EN: misalign_err SHALL be tied to 0, and low address bits SHALL be ignored for word accesses.

Structure
REQ-024 A shared package pipe_pkg SHALL hold: the FSM state typedef, BE_WORD = 4'hF, RA_ADDR = 5'd31, and the 32-bit data width constant.
REQ-025 The byte-lane select and extension SHALL be the combinational sub-module load_align (rdata, offset, byte, sign -> data).

Verification
REQ-026 Non-memory op REG_WRITE = 0x1234, REG_WRITE_ADDR = 5, RegWr_MEM = 1 -> next cycle REG_WRITE_DATA_WB = 0x1234, REG_WRITE_ADDR_WB = 5, stall never 1.
REQ-027 Word load from 0x100, ack after 3 BUSY cycles, rdata = 0xDEADBEEF -> stall high for 4 cycles; WB data 0xDEADBEEF one edge after ack; dmem_req deasserted after the ack edge.
REQ-028 Byte load from 0x103, rdata = 0x80112233: SigCtr = 1 -> 0xFFFFFF80; SigCtr = 0 -> 0x00000080.
REQ-029 Byte store 0xAB to 0x102 -> dmem_be = 4'b0100, dmem_wdata = 0xABABABAB, dmem_we = 1; RegWr_WB = 0 when RegWr_MEM = 0.
REQ-030 rst = 0 in BUSY, then ack 1 cycle later -> state IDLE, dmem_req = 0, all WB outputs 0; ack ignored.
REQ-031 With ALIGN_CHECK_EN, word load from 0x102 -> no dmem_req, misalign_err pulses once, RegWr_WB = 0; without the macro -> access at 0x100.
